ahbl_timer_slave: RTL and testbench

//  AHB-Lite slave timer on the CPU's data bus, downstream of the RV32 AHB-Lite master.

---
 rtl/ahbl_timer_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_ahbl_timer_slave.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_timer_slave.sv
// AHB-Lite slave timer: prescaled down-counter with auto-reload, a sticky timeout flag,
// a level interrupt, zero-wait OKAY transfers and a two-cycle ERROR response.
module ahbl_timer_slave #(
    parameter int PRE_W = 16,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic        irq
);

    typedef enum logic [1:0] {
        RESP_OKAY = 2'd0,
        RESP_ERR1 = 2'd1,
        RESP_ERR2 = 2'd2
    } resp_state_t;

    localparam logic [PRE_W-1:0] PCNT_ONE = {{(PRE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            3'b000:  be = 4'b0001 << a;
            3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic illegal_of(input logic [2:0] size, input logic [4:0] a);
        return (a > 5'h10) || (size > 3'b010) ||
               ((size == 3'b001) && a[0]) ||
               ((size == 3'b010) && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    resp_state_t      state_r, state_s;
    logic             dphase_r, write_r;
    logic [4:0]       addr_r;
    logic [3:0]       lanes_r;
    logic [2:0]       ctrl_r;
    logic [PRE_W-1:0] prescale_r, pcnt_r;
    logic [CNT_W-1:0] load_r, count_r;
    logic             to_r;

    logic        accept_s, illegal_s, tick_s, zero_s, wr_s;
    logic        wr_ctrl_s, wr_pre_s, wr_load_s, wr_count_s, w1c_s;
    logic [31:0] reg_s, merged_s;
    logic        unused_addr_s;

    assign accept_s      = HSEL & HTRANS & HREADY;
    assign illegal_s     = illegal_of(HSIZE, HADDR[4:0]);
    assign unused_addr_s = ^HADDR[31:5];

    assign tick_s = ctrl_r[0] & (pcnt_r == prescale_r);
    assign zero_s = (count_r == {CNT_W{1'b0}});

    assign wr_s       = dphase_r & write_r;
    assign wr_ctrl_s  = wr_s & (addr_r[4:2] == 3'd0);
    assign wr_pre_s   = wr_s & (addr_r[4:2] == 3'd1);
    assign wr_load_s  = wr_s & (addr_r[4:2] == 3'd2);
    assign wr_count_s = wr_s & (addr_r[4:2] == 3'd3);
    assign w1c_s      = wr_s & (addr_r[4:2] == 3'd4) & lanes_r[0] & HWDATA[0];

    // Register selected by the data-phase address; feeds both read data and write merging
    always_comb begin
        reg_s = 32'd0;
        case (addr_r[4:2])
            3'd0:    reg_s[2:0]       = ctrl_r;
            3'd1:    reg_s[PRE_W-1:0] = prescale_r;
            3'd2:    reg_s[CNT_W-1:0] = load_r;
            3'd3:    reg_s[CNT_W-1:0] = count_r;
            3'd4:    reg_s[0]         = to_r;
            default: reg_s            = 32'd0;
        endcase
    end

    assign merged_s = merge_lanes(reg_s, HWDATA, lanes_r);

    // Read data only while a legal read is in its data phase
    always_comb begin
        if (dphase_r && !write_r) begin
            HRDATA = reg_s;
        end else begin
            HRDATA = 32'd0;
        end
    end

    assign irq = to_r & ctrl_r[1];

    // Address-phase capture; illegal accesses never open a data phase
    always_ff @(posedge clk) begin
        if (rst) begin
            dphase_r <= 1'b0;
            write_r  <= 1'b0;
            addr_r   <= 5'd0;
            lanes_r  <= 4'd0;
        end else begin
            dphase_r <= accept_s & ~illegal_s;
            if (accept_s) begin
                write_r <= HWRITE;
                addr_r  <= HADDR[4:0];
                lanes_r <= lanes_of(HSIZE, HADDR[1:0]);
            end
        end
    end

    // Response state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RESP_OKAY;
        end else begin
            state_r <= state_s;
        end
    end

    // Response next state and HREADYOUT/HRESP decode
    always_comb begin
        state_s   = state_r;
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        case (state_r)
            RESP_OKAY: begin
                if (accept_s && illegal_s) begin
                    state_s = RESP_ERR1;
                end else begin
                    state_s = RESP_OKAY;
                end
            end
            RESP_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
                state_s   = RESP_ERR2;
            end
            RESP_ERR2: begin
                HRESP = 2'b01;
                if (accept_s && illegal_s) begin
                    state_s = RESP_ERR1;
                end else begin
                    state_s = RESP_OKAY;
                end
            end
            default: begin
                state_s = RESP_OKAY;
            end
        endcase
    end

    // Timer registers; bus writes take priority over tick effects, except TO set beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r     <= 3'd0;
            prescale_r <= {PRE_W{1'b0}};
            load_r     <= {CNT_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            to_r       <= 1'b0;
            pcnt_r     <= {PRE_W{1'b0}};
        end else begin
            if (!ctrl_r[0] || tick_s) begin
                pcnt_r <= {PRE_W{1'b0}};
            end else begin
                pcnt_r <= pcnt_r + PCNT_ONE;
            end

            if (wr_ctrl_s) begin
                ctrl_r <= merged_s[2:0];
            end else if (tick_s && zero_s && !ctrl_r[2]) begin
                ctrl_r[0] <= 1'b0;
            end

            if (wr_pre_s) begin
                prescale_r <= merged_s[PRE_W-1:0];
            end

            if (wr_load_s) begin
                load_r <= merged_s[CNT_W-1:0];
            end

            if (wr_count_s) begin
                count_r <= merged_s[CNT_W-1:0];
            end else if (tick_s && !zero_s) begin
                count_r <= count_r - CNT_ONE;
            end else if (tick_s && ctrl_r[2]) begin
                count_r <= load_r;
            end

            if (tick_s && zero_s) begin
                to_r <= 1'b1;
            end else if (w1c_s) begin
                to_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_timer_slave.sv
// Bench for ahbl_timer_slave: a cycle-level model of the register map and timer rules,
// checked against every output on every cycle, plus directed vectors with literal expectations.
module tb_ahbl_timer_slave;

    logic        clk = 1'b0;
    logic        rst, HSEL, HTRANS, HWRITE, HREADY, HREADYOUT, irq;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HRESP;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Single-slave bus: the slave's own ready closes the loop
    assign HREADY = HREADYOUT;

    ahbl_timer_slave dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model state: registers as plain values, response state 0=OKAY 1=ERR1 2=ERR2
    logic [2:0]  m_ctrl = 3'd0;
    logic [31:0] m_pre = 32'd0, m_load = 32'd0, m_cnt = 32'd0;
    bit          m_to = 1'b0, m_dp = 1'b0, m_dw = 1'b0;
    int unsigned m_pcnt = 0;
    int          m_da = 0, m_dsz = 0, m_st = 0;

    function automatic logic [31:0] m_reg(input int idx);
        case (idx)
            0:       return {29'd0, m_ctrl};
            1:       return m_pre;
            2:       return m_load;
            3:       return m_cnt;
            4:       return {31'd0, m_to};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit tick, expire, acc, bad;
        logic [31:0] v;
        int idx, first, nb, off;
        if (rst) begin
            m_ctrl = 3'd0; m_pre = 32'd0; m_load = 32'd0; m_cnt = 32'd0; m_to = 1'b0;
            m_pcnt = 0; m_dp = 1'b0; m_dw = 1'b0; m_da = 0; m_dsz = 0; m_st = 0;
            return;
        end
        tick   = m_ctrl[0] && (m_pcnt == m_pre);
        expire = tick && (m_cnt == 32'd0);
        idx    = m_da / 4;
        first  = m_da % 4;
        nb     = 1 << m_dsz;
        v      = m_reg(idx);
        for (int k = 0; k < 4; k++) begin
            if (k >= first && k < first + nb) v[8*k +: 8] = HWDATA[8*k +: 8];
        end
        m_pcnt = (!m_ctrl[0] || tick) ? 0 : (m_pcnt + 1) % 65536;
        if (tick && !expire) m_cnt = m_cnt - 32'd1;
        if (expire) begin
            m_to = 1'b1;
            if (m_ctrl[2]) m_cnt = m_load;
            else           m_ctrl[0] = 1'b0;
        end
        if (m_dp && m_dw) begin
            case (idx)
                0: m_ctrl = v[2:0];
                1: m_pre  = v & 32'h0000_FFFF;
                2: m_load = v;
                3: m_cnt  = v;
                4: if (first == 0 && HWDATA[0] && !expire) m_to = 1'b0;
                default: ;
            endcase
        end
        acc = HSEL && HTRANS && HREADY;
        off = int'(HADDR[4:0]);
        bad = (off > 16) || (HSIZE > 3'd2) || ((off % (1 << HSIZE)) != 0);
        if (m_st == 1)        m_st = 2;
        else if (acc && bad)  m_st = 1;
        else                  m_st = 0;
        m_dp = acc && !bad;
        if (acc) begin
            m_dw  = HWRITE;
            m_da  = off;
            m_dsz = int'(HSIZE);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("hrdata", HRDATA, (m_dp && !m_dw) ? m_reg(m_da / 4) : 32'd0);
            check("hreadyout", 32'(HREADYOUT), (m_st == 1) ? 32'd0 : 32'd1);
            check("hresp", 32'(HRESP), (m_st == 0) ? 32'd0 : 32'd1);
            check("irq", 32'(irq), 32'(m_to && m_ctrl[1]));
        end
    end

    task automatic ahb(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                       input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] resp);
        int n;
        bit done;
        HSEL = 1'b1; HTRANS = 1'b1; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 1'b0; HWDATA = wd;
        n = 0; done = 1'b0; rd = 32'd0; resp = 2'b00;
        while (!done && n < 8) begin
            @(negedge clk);
            if (n == 0) begin
                rd = HRDATA;
                resp = HRESP;
            end
            done = HREADYOUT;
            n++;
            @(posedge clk); #1;
        end
        check("ahb_done", 32'(done), 32'd1);
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic [1:0]  rs;
        ahb(a, 1'b1, 3'b010, d, r, rs);
    endtask

    task automatic rd32(input logic [31:0] a, output logic [31:0] d);
        logic [1:0] rs;
        ahb(a, 1'b0, 3'b010, 32'd0, d, rs);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [1:0]  rs;
        int n;
        rst = 1'b1; HSEL = 1'b0; HTRANS = 1'b0; HWRITE = 1'b0; HSIZE = 3'd0;
        HADDR = 32'd0; HWDATA = 32'd0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        for (int a = 0; a <= 16; a += 4) begin
            rd32(32'(a), r);
            check($sformatf("reset_reg_%0h", a), r, 32'd0);
        end
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_hresp", 32'(HRESP), 32'd0);

        // Auto-reload, PRESCALE=0: TO four cycles after EN
        wr32(32'h04, 32'd0); wr32(32'h08, 32'd3); wr32(32'h0C, 32'd3); wr32(32'h00, 32'd7);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (irq) begin
                n = i;
                break;
            end
        end
        check("to_latency", 32'(n), 32'd4);
        rd32(32'h0C, r);
        check("count_after_reload", r, 32'd2);   // reloaded to 3, one tick since
        @(posedge clk); #1;
        wr32(32'h10, 32'd1);
        check("irq_after_w1c", 32'(irq), 32'd0);
        wr32(32'h00, 32'd0); wr32(32'h10, 32'd1);
        rd32(32'h10, r);
        check("status_cleared", r, 32'd0);

        // One-shot, PRESCALE=2: ticks every third cycle
        wr32(32'h04, 32'd2); wr32(32'h0C, 32'd1); wr32(32'h00, 32'd1);
        rd32(32'h0C, r);  check("pre2_before_tick", r, 32'd1);
        rd32(32'h0C, r);  check("pre2_after_tick", r, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rd32(32'h00, r);  check("oneshot_en_cleared", r, 32'd0);
        rd32(32'h10, r);  check("oneshot_to", r, 32'd1);
        rd32(32'h0C, r);  check("oneshot_count", r, 32'd0);
        wr32(32'h10, 32'd1);

        // Byte lane write and misaligned / oversized accesses
        wr32(32'h08, 32'd0);
        ahb(32'h09, 1'b1, 3'b000, 32'hABAB_ABAB, r, rs);
        check("byte_write_resp", 32'(rs), 32'd0);
        rd32(32'h08, r);  check("byte_write_load", r, 32'h0000_AB00);
        wr32(32'h0C, 32'h1234);
        ahb(32'h0D, 1'b1, 3'b001, 32'hFFFF_FFFF, r, rs);
        check("half_misaligned_resp", 32'(rs), 32'd1);
        rd32(32'h0C, r);  check("count_unchanged", r, 32'h1234);
        ahb(32'h00, 1'b0, 3'b011, 32'd0, r, rs);
        check("size3_resp", 32'(rs), 32'd1);

        // Unmapped read followed back-to-back by a valid read during ERR2
        wr32(32'h00, 32'd2);
        HSEL = 1'b1; HTRANS = 1'b1; HADDR = 32'h14; HWRITE = 1'b0; HSIZE = 3'b010;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 1'b0;
        @(negedge clk);
        check("err1_ready", 32'(HREADYOUT), 32'd0);
        check("err1_resp", 32'(HRESP), 32'd1);
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 1'b1; HADDR = 32'h00;
        @(negedge clk);
        check("err2_ready", 32'(HREADYOUT), 32'd1);
        check("err2_resp", 32'(HRESP), 32'd1);
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 1'b0;
        @(negedge clk);
        check("b2b_resp", 32'(HRESP), 32'd0);
        check("b2b_rdata", HRDATA, 32'd2);
        @(posedge clk); #1;

        // COUNT write lands on the same edge as a tick at COUNT=5
        wr32(32'h00, 32'd0); wr32(32'h10, 32'd1); wr32(32'h04, 32'd2);
        wr32(32'h0C, 32'd5); wr32(32'h00, 32'd1);
        @(posedge clk); #1;
        wr32(32'h0C, 32'h10);
        rd32(32'h0C, r);  check("count_write_wins", r, 32'h10);

        // W1C on the edge where TO sets
        wr32(32'h00, 32'd0); wr32(32'h10, 32'd1); wr32(32'h04, 32'd0);
        wr32(32'h0C, 32'd1); wr32(32'h00, 32'd1);
        wr32(32'h10, 32'd1);
        rd32(32'h10, r);  check("to_set_wins", r, 32'd1);
        rd32(32'h00, r);  check("en_auto_cleared", r, 32'd0);

        // CTRL write on the edge of the one-shot EN auto-clear
        wr32(32'h10, 32'd1); wr32(32'h08, 32'h100); wr32(32'h0C, 32'd1); wr32(32'h00, 32'd1);
        wr32(32'h00, 32'd5);
        rd32(32'h00, r);  check("ctrl_write_wins", r, 32'd5);
        wr32(32'h00, 32'd0);

        // Reset during a write data phase drops the write
        HSEL = 1'b1; HTRANS = 1'b1; HADDR = 32'h0C; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 1'b0; HWDATA = 32'hDEAD_BEEF; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd32(32'h0C, r);  check("reset_drops_write", r, 32'd0);
        rd32(32'h08, r);  check("reset_clears_load", r, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
